// File: rtl/dram_port_arbiter_pkg.sv
// Shared types and DRAM port constants for the bridge-side arbiter.
// The address and data widths here must match the bridge's C_addr / C_data_* ports.
package dram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_t;

    localparam int DRAM_ADDR_W = 8;
    localparam int DRAM_DATA_W = 64;

    // Index width that stays at least 1 bit even for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dram_port_arbiter_rr_grant.sv
// Combinational round-robin picker: the first valid requester starting at ptr wins.
// It returns the winner as a one-hot vector and as a binary index.
module dram_port_arbiter_rr_grant
    import dram_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!any && valid[(int'(ptr) + off) % NUM_REQ]) begin
                any                                   = 1'b1;
                grant[(int'(ptr) + off) % NUM_REQ]    = 1'b1;
                idx                                   = IDX_W'((int'(ptr) + off) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares one bridge access port between NUM_REQ requesters, with one transaction in flight at a time.
// Grants go round-robin, the issue to the bridge is registered, and the response returns to the owner.
module dram_port_arbiter
    import dram_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = DRAM_ADDR_W,
    parameter int DATA_W  = DRAM_DATA_W,
    parameter int TIMEOUT = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_r_wb,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      C_in_valid,
    output logic                      C_r_wb,
    output logic [ADDR_W-1:0]         C_addr,
    output logic [DATA_W-1:0]         C_data_w,
    input  logic                      C_out_valid,
    input  logic [DATA_W-1:0]         C_data_r,
    output logic                      busy,
    output logic                      err_timeout
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    arb_state_t          state, next_state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    owner;
    logic                r_wb_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [CNT_W-1:0]    wait_cnt;
    logic                err_q;

    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_any;
    logic                accept;

    dram_port_arbiter_rr_grant #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_grant (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    // Ready is offered only in IDLE, so a grant and a handshake are the same event.
    assign accept = (state == ARB_IDLE) && grant_any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ARB_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        req_ready  = '0;
        case (state)
            ARB_IDLE: begin
                if (grant_any) begin
                    req_ready  = grant;
                    next_state = ARB_ISSUE;
                end
            end
            ARB_ISSUE: next_state = ARB_WAIT;
            ARB_WAIT:  if (C_out_valid) next_state = ARB_RESP;
            ARB_RESP:  next_state = ARB_IDLE;
            default:   next_state = ARB_IDLE;
        endcase
    end

    // The request latch doubles as the bridge-facing hold register until the next handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner   <= '0;
            r_wb_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            owner   <= grant_idx;
            r_wb_q  <= req_r_wb[grant_idx];
            addr_q  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
            wdata_q <= req_wdata[grant_idx*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= '0;
        else if (state == ARB_RESP)
            rr_ptr <= (owner == IDX_LAST) ? '0 : owner + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata_q <= '0;
        else if (state == ARB_WAIT && C_out_valid)
            rdata_q <= C_data_r;
    end

    // The counter saturates at TIMEOUT so the sticky flag keeps a stable cause.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (state == ARB_ISSUE)
            wait_cnt <= '0;
        else if (state == ARB_WAIT && !C_out_valid && wait_cnt != CNT_MAX)
            wait_cnt <= wait_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if ((state == ARB_WAIT && wait_cnt == CNT_MAX) ||
                 (state != ARB_WAIT && C_out_valid))
            err_q <= 1'b1;
    end

    always_comb begin
        rsp_valid = '0;
        if (state == ARB_RESP) rsp_valid[owner] = 1'b1;
    end

    assign rsp_rdata   = rdata_q;
    assign C_in_valid  = (state == ARB_ISSUE);
    assign C_r_wb      = r_wb_q;
    assign C_addr      = addr_q;
    assign C_data_w    = wdata_q;
    assign busy        = (state != ARB_IDLE);
    assign err_timeout = err_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Scenario bench for dram_port_arbiter: each response is predicted when its request is accepted.
// The prediction is pushed into a queue and checked against the response when it completes.
module tb_dram_port_arbiter;

    localparam int N  = 2;
    localparam int AW = 8;
    localparam int DW = 64;

    typedef struct packed {
        logic [N-1:0]  who;
        logic [DW-1:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_r_wb = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            C_in_valid;
    logic            C_r_wb;
    logic [AW-1:0]   C_addr;
    logic [DW-1:0]   C_data_w;
    logic            C_out_valid = 1'b0;
    logic [DW-1:0]   C_data_r = '0;
    logic            busy;
    logic            err_timeout;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    dram_port_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_r_wb    (req_r_wb),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .C_in_valid  (C_in_valid),
        .C_r_wb      (C_r_wb),
        .C_addr      (C_addr),
        .C_data_w    (C_data_w),
        .C_out_valid (C_out_valid),
        .C_data_r    (C_data_r),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        req_valid = '0;
        C_out_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // This task is entered in the ISSUE cycle. It waits `waits` cycles in WAIT and then completes with d.
    task automatic run_bridge(input logic [DW-1:0] d, input int waits, input string tag);
        exp_t e;
        vectors++;
        if (C_in_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s issue: C_in_valid=%b want 1", tag, C_in_valid);
        end
        tick();
        vectors++;
        if (C_in_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s pulse: C_in_valid=%b want 0", tag, C_in_valid);
        end
        repeat (waits) tick();
        C_out_valid = 1'b1;
        C_data_r = d;
        tick();
        C_out_valid = 1'b0;
        C_data_r = '0;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s rsp: got rsp_valid=%b with no expectation", tag, rsp_valid);
        end else begin
            e = sb.pop_front();
            if (rsp_valid !== e.who || rsp_rdata !== e.data) begin
                miscompares++;
                $display("FAIL %s rsp: got %b/%h want %b/%h", tag, rsp_valid, rsp_rdata, e.who, e.data);
            end
        end
        tick();
        vectors++;
        if (rsp_valid !== '0) begin
            miscompares++;
            $display("FAIL %s rsp_end: rsp_valid=%b want 0", tag, rsp_valid);
        end
    endtask

    task automatic test_reset();
        tick();
        vectors++;
        if ({req_ready, rsp_valid, C_in_valid, C_r_wb, C_addr, C_data_w, busy, err_timeout} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: ready=%b rsp=%b inv=%b rwb=%b addr=%h wd=%h busy=%b err=%b want all 0",
                     req_ready, rsp_valid, C_in_valid, C_r_wb, C_addr, C_data_w, busy, err_timeout);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        req_r_wb = 2'b01;
        req_addr[0 +: AW] = 8'h10;
        req_valid = 2'b01;
        #1;
        vectors++;
        if (req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL read_ready: req_ready=%b want 01", req_ready);
        end
        sb.push_back(exp_t'{2'b01, 64'hDEAD_BEEF_0000_0001});
        tick();
        req_valid = '0;
        vectors++;
        if (C_addr !== 8'h10 || C_r_wb !== 1'b1 || busy !== 1'b1 || req_ready !== '0) begin
            miscompares++;
            $display("FAIL read_issue: addr=%h rwb=%b busy=%b ready=%b want 10/1/1/00",
                     C_addr, C_r_wb, busy, req_ready);
        end
        run_bridge(64'hDEAD_BEEF_0000_0001, 0, "read");
    endtask

    task automatic test_contention();
        reset_dut();
        req_r_wb = 2'b11;
        req_addr[0 +: AW]  = 8'h20;
        req_addr[AW +: AW] = 8'h21;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            logic [N-1:0]  w;
            logic [AW-1:0] a;
            w = (k % 2 == 0) ? 2'b01 : 2'b10;
            a = (k % 2 == 0) ? 8'h20 : 8'h21;
            #1;
            vectors++;
            if (req_ready !== w) begin
                miscompares++;
                $display("FAIL cont_grant%0d: req_ready=%b want %b", k, req_ready, w);
            end
            sb.push_back(exp_t'{w, 64'hC0 + 64'(k)});
            tick();
            vectors++;
            if (C_addr !== a) begin
                miscompares++;
                $display("FAIL cont_addr%0d: C_addr=%h want %h", k, C_addr, a);
            end
            run_bridge(64'hC0 + 64'(k), k, "cont");
        end
        req_valid = '0;
    endtask

    task automatic test_write();
        req_r_wb = 2'b01;
        req_addr[AW +: AW] = 8'hFF;
        req_wdata[DW +: DW] = 64'h1234;
        req_valid = 2'b10;
        #1;
        vectors++;
        if (req_ready !== 2'b10) begin
            miscompares++;
            $display("FAIL write_ready: req_ready=%b want 10", req_ready);
        end
        sb.push_back(exp_t'{2'b10, 64'h5A5A});
        tick();
        req_valid = '0;
        req_wdata[DW +: DW] = 64'hBAD;
        vectors++;
        if (C_r_wb !== 1'b0 || C_data_w !== 64'h1234 || C_addr !== 8'hFF) begin
            miscompares++;
            $display("FAIL write_issue: rwb=%b wd=%h addr=%h want 0/1234/ff", C_r_wb, C_data_w, C_addr);
        end
        run_bridge(64'h5A5A, 2, "write");
        vectors++;
        if (C_data_w !== 64'h1234 || C_addr !== 8'hFF || C_r_wb !== 1'b0) begin
            miscompares++;
            $display("FAIL write_hold: wd=%h addr=%h rwb=%b want 1234/ff/0", C_data_w, C_addr, C_r_wb);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        req_r_wb = 2'b11;
        req_addr[0 +: AW] = 8'h33;
        req_valid = 2'b01;
        #1;
        sb.push_back(exp_t'{2'b01, 64'h7777});
        tick();
        req_valid = '0;
        tick();
        repeat (8) tick();
        vectors++;
        if (err_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early: err_timeout=%b want 0 at WAIT cycle 8", err_timeout);
        end
        tick();
        vectors++;
        if (err_timeout !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_set: err=%b busy=%b want 1/1", err_timeout, busy);
        end
        C_out_valid = 1'b1;
        C_data_r = 64'h7777;
        tick();
        C_out_valid = 1'b0;
        C_data_r = '0;
        vectors++;
        e = sb.pop_front();
        if (rsp_valid !== e.who || rsp_rdata !== e.data || err_timeout !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_late_rsp: got %b/%h err=%b want %b/%h err=1",
                     rsp_valid, rsp_rdata, err_timeout, e.who, e.data);
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || err_timeout !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_after: busy=%b err=%b want 0/1", busy, err_timeout);
        end
    endtask

    task automatic test_spurious();
        reset_dut();
        vectors++;
        if (err_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL spur_clear: err_timeout=%b want 0", err_timeout);
        end
        C_out_valid = 1'b1;
        C_data_r = 64'hFFFF;
        tick();
        C_out_valid = 1'b0;
        vectors++;
        if (err_timeout !== 1'b1 || rsp_valid !== '0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL spur_idle: err=%b rsp=%b busy=%b want 1/00/0", err_timeout, rsp_valid, busy);
        end
        tick();
        vectors++;
        if (rsp_valid !== '0) begin
            miscompares++;
            $display("FAIL spur_norsp: rsp_valid=%b want 00", rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        req_r_wb = 2'b11;
        req_addr[0 +: AW] = 8'h44;
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        tick();
        rst = 1'b1;
        #1;
        vectors++;
        if ({rsp_valid, C_in_valid, C_r_wb, C_addr, C_data_w, busy, err_timeout} !== '0) begin
            miscompares++;
            $display("FAIL midrst_async: rsp=%b inv=%b rwb=%b addr=%h busy=%b err=%b want all 0",
                     rsp_valid, C_in_valid, C_r_wb, C_addr, busy, err_timeout);
        end
        tick();
        vectors++;
        if (rsp_valid !== '0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_edge: rsp=%b busy=%b want 00/0", rsp_valid, busy);
        end
        rst = 1'b0;
        req_addr[0 +: AW] = 8'h55;
        req_valid = 2'b01;
        #1;
        vectors++;
        if (req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL midrst_ready: req_ready=%b want 01", req_ready);
        end
        sb.push_back(exp_t'{2'b01, 64'h5555_0000});
        tick();
        req_valid = '0;
        vectors++;
        if (C_addr !== 8'h55) begin
            miscompares++;
            $display("FAIL midrst_addr: C_addr=%h want 55", C_addr);
        end
        run_bridge(64'h5555_0000, 1, "midrst");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_write();
        test_timeout();
        test_spurious();
        test_reset_mid();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
